audio_monitor: RTL and testbench
================================

Name: audio_monitor

Overview:
- Synthesizable, N-channel, self-checking audio monitor that replaces testbench-only frequency/amplitude checks.
- Taps the signed sample streams sent to the codec and detects negative-to-positive zero crossings on each channel.
- Per crossing it measures period (samples) and positive peak, compares against runtime limits, and counts violations.
- Sits beside the codec interface in the Equalizer; results are readable by the bench and by LED/debug logic.

Parameters:
- NUM_CH, 2, number of audio channels (ch0 = left, ch1 = right).
- DATA_W, 16, signed sample width.
- CNT_W, 16, width of the period counter and period limits.
- ERR_W, 16, width of each error counter.
- WIN_W, 24, width of the measurement-window sample counter.
- WARMUP, 10, rising zero crossings skipped per channel before checking starts.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- smpl_vld  in  1  one-cycle strobe; all channels have a new sample
- aud_in  in  NUM_CH*DATA_W  packed signed samples; ch k at bits [k*DATA_W +: DATA_W]
- start  in  1  pulse; begins a measurement run
- win_len  in  WIN_W  run length in valid samples, counted after all channels finish warm-up
- min_period, max_period  in  CNT_W each  inclusive period limits
- min_ampl, max_ampl  in  DATA_W each  inclusive signed peak limits
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- freq_err  out  NUM_CH*ERR_W  per-channel period-violation counts
- ampl_err  out  NUM_CH*ERR_W  per-channel peak-violation counts
- no_cross  out  NUM_CH  channel saw no checked crossing during the MEASURE window
- last_period  out  NUM_CH*CNT_W  most recent completed period per channel

Behaviour:
- Reset: all outputs 0; all FSMs in IDLE; internal counters 0.
- Samples are processed only on cycles with smpl_vld=1. Sign state is tracked per sample, not per clock.
- Crossing definition: previous sample sign bit = 1 and current sample sign bit = 0. The first sample after start has no predecessor and is never a crossing.
- Period counter:
  - Loads 1 on a crossing sample; increments on every other valid sample.
  - Saturates at all-ones.
  - The value held just before reload is the completed period. A 16-sample sine therefore yields 16.
- Peak register: loads the crossing sample's value, then takes signed max on each following valid sample.
- Channel FSM (IDLE, WARMUP, MEASURE, DONE):
  - IDLE -> WARMUP on start: error counts, no_cross, and crossing count cleared; no_cross set to 1.
  - WARMUP -> MEASURE on the WARMUP-th crossing; that crossing opens the first checked period.
  - In MEASURE, each crossing does all of the following:
    - freq_err += 1 if period < min_period or period > max_period.
    - ampl_err += 1 if peak < min_ampl or peak > max_ampl.
    - last_period updated; no_cross cleared.
  - Both error counters may increment on the same crossing. Error counters saturate and never wrap.
- Global window control:
  - The window counter starts once every channel has left WARMUP and counts valid samples.
  - When the count reaches win_len, all channels go to DONE. done pulses the following cycle, then all return to IDLE.
  - busy = 1 from the cycle after start until done.
  - win_len = 0 ends the run immediately after warm-up.
- A crossing coincident with the terminal window sample is still checked.
- start while busy is ignored.
- A channel stuck in WARMUP stalls the run indefinitely. The bench must bound the run time.
- Limits are sampled at start and held constant for the whole run.
- rst_n asserted mid-run aborts immediately to the reset state; no done pulse is generated.
- Latency: error counters and last_period update 1 cycle after the crossing sample's smpl_vld.

Decomposition:
- Package audio_mon_pkg holds:
  - The channel state enum (IDLE, WARMUP, MEASURE, DONE).
  - A saturating-increment function.
  - Default limit constants: 572/954 samples and 2400/4000 amplitude.
- Sub-module audio_mon_chan: one channel's sign tracking, period/peak registers, FSM and error counters. It is instantiated NUM_CH times in a generate loop.
- The top level holds the start/limit capture, window counter, done generation, and port packing.

Test Plan:
- Sine, period 16, peak 3000, both channels; limits 12..20 and 2400..4000; WARMUP 10; win_len 1600 -> done pulses once; freq_err = ampl_err = 0; last_period = 16; no_cross = 0.
- ch0 square wave of period 40, peak 3000; ch1 as the first scenario; win_len 4000 -> ch0 freq_err = 100, ch1 freq_err = 0; ampl_err = 0 on both.
- ch1 sine, period 16, peak 5000 -> ch1 ampl_err = win_len/16; ch1 freq_err = 0.
- ch0 held at constant +100 -> run never leaves WARMUP and busy stays 1. Then a separate run with WARMUP = 0 -> done occurs and no_cross[0] = 1.
- Force ERR_W = 4 and use an out-of-range period for 20 crossings -> counter stays at 15.
- start pulsed while busy -> no restart and counts unaffected; rst_n low mid-run -> all outputs 0, no done pulse; a new start then works normally.

Source files
------------

// File: rtl/audio_mon_pkg.sv
// ============================================================================
// Module      : audio_mon_pkg
// Description : Shared channel-state encoding, default limits and helpers
//               for the audio monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package audio_mon_pkg;

  typedef logic [1:0] chan_state_t;

  localparam chan_state_t c_st_idle    = 2'd0;
  localparam chan_state_t c_st_warmup  = 2'd1;
  localparam chan_state_t c_st_measure = 2'd2;
  localparam chan_state_t c_st_done    = 2'd3;

  // Default limits in samples / signed amplitude
  localparam int c_def_min_period = 572;
  localparam int c_def_max_period = 954;
  localparam int c_def_min_ampl   = 2400;
  localparam int c_def_max_ampl   = 4000;

  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_val);
    return (value >= max_val) ? value : value + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/audio_mon_chan.sv
// ============================================================================
// Module      : audio_mon_chan
// Description : One audio channel: rising zero-crossing detection, period and
//               peak measurement, warm-up/measure FSM and violation counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_mon_chan
  import audio_mon_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16,
  parameter int ERR_W  = 16,
  parameter int WARMUP = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     smpl_vld,
  input  logic signed [DATA_W-1:0] sample,
  input  logic                     go,
  input  logic                     stop,
  input  logic [CNT_W-1:0]         min_period,
  input  logic [CNT_W-1:0]         max_period,
  input  logic signed [DATA_W-1:0] min_ampl,
  input  logic signed [DATA_W-1:0] max_ampl,
  output logic                     measuring,
  output logic [ERR_W-1:0]         freq_err,
  output logic [ERR_W-1:0]         ampl_err,
  output logic                     no_cross,
  output logic [CNT_W-1:0]         last_period
);

  localparam int          c_xw      = (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);
  localparam logic [31:0] c_cnt_max = 32'({CNT_W{1'b1}});
  localparam logic [31:0] c_err_max = 32'({ERR_W{1'b1}});
  localparam logic [31:0] c_x_max   = 32'({c_xw{1'b1}});

  chan_state_t              r_state;
  logic                     r_prev_neg;
  logic                     r_have_prev;
  logic                     r_open;
  logic                     r_no_cross;
  logic [c_xw-1:0]          r_xcnt;
  logic [CNT_W-1:0]         r_period;
  logic [CNT_W-1:0]         r_last_period;
  logic signed [DATA_W-1:0] r_peak;
  logic [ERR_W-1:0]         r_freq_err;
  logic [ERR_W-1:0]         r_ampl_err;

  logic w_active, w_cross, w_warm_done, w_check, w_freq_bad, w_ampl_bad;

  assign w_active    = (r_state == c_st_warmup) || (r_state == c_st_measure);
  assign w_cross     = smpl_vld && w_active && r_have_prev && r_prev_neg && !sample[DATA_W-1];
  assign w_warm_done = (WARMUP == 0) || (w_cross && ((32'(r_xcnt) + 32'd1) >= 32'(WARMUP)));
  // Only a crossing that closes a period opened in this run is judged
  assign w_check     = w_cross && r_open && (r_state == c_st_measure);
  assign w_freq_bad  = (r_period < min_period) || (r_period > max_period);
  assign w_ampl_bad  = (r_peak < min_ampl) || (r_peak > max_ampl);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_st_idle;
      r_prev_neg    <= 1'b0;
      r_have_prev   <= 1'b0;
      r_open        <= 1'b0;
      r_no_cross    <= 1'b0;
      r_xcnt        <= '0;
      r_period      <= '0;
      r_last_period <= '0;
      r_peak        <= '0;
      r_freq_err    <= '0;
      r_ampl_err    <= '0;
    end else if (go) begin
      r_state     <= c_st_warmup;
      r_prev_neg  <= 1'b0;
      r_have_prev <= 1'b0;
      r_open      <= 1'b0;
      r_no_cross  <= 1'b1;
      r_xcnt      <= '0;
      r_period    <= '0;
      r_peak      <= '0;
      r_freq_err  <= '0;
      r_ampl_err  <= '0;
    end else begin
      case (r_state)
        c_st_warmup:  if (w_warm_done) r_state <= c_st_measure;
        c_st_measure: if (stop) r_state <= c_st_done;
        c_st_done:    r_state <= c_st_idle;
        default:      r_state <= c_st_idle;
      endcase

      if (smpl_vld && w_active) begin
        r_have_prev <= 1'b1;
        r_prev_neg  <= sample[DATA_W-1];
        if (w_cross) begin
          r_period <= CNT_W'(1);
          r_peak   <= sample;
          r_open   <= 1'b1;
        end else begin
          r_period <= CNT_W'(sat_inc(32'(r_period), c_cnt_max));
          if (sample > r_peak) r_peak <= sample;
        end
      end

      if (w_cross && (r_state == c_st_warmup))
        r_xcnt <= c_xw'(sat_inc(32'(r_xcnt), c_x_max));

      if (w_check) begin
        if (w_freq_bad) r_freq_err <= ERR_W'(sat_inc(32'(r_freq_err), c_err_max));
        if (w_ampl_bad) r_ampl_err <= ERR_W'(sat_inc(32'(r_ampl_err), c_err_max));
        r_last_period <= r_period;
        r_no_cross    <= 1'b0;
      end
    end
  end

  assign measuring   = (r_state == c_st_measure);
  assign freq_err    = r_freq_err;
  assign ampl_err    = r_ampl_err;
  assign no_cross    = r_no_cross;
  assign last_period = r_last_period;

endmodule

`default_nettype wire

// File: rtl/audio_monitor.sv
// ============================================================================
// Module      : audio_monitor
// Description : N-channel audio monitor: run control, limit capture, window
//               counter, done generation and per-channel result packing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_monitor
  import audio_mon_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16,
  parameter int ERR_W  = 16,
  parameter int WIN_W  = 24,
  parameter int WARMUP = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     smpl_vld,
  input  logic [NUM_CH*DATA_W-1:0] aud_in,
  input  logic                     start,
  input  logic [WIN_W-1:0]         win_len,
  input  logic [CNT_W-1:0]         min_period,
  input  logic [CNT_W-1:0]         max_period,
  input  logic [DATA_W-1:0]        min_ampl,
  input  logic [DATA_W-1:0]        max_ampl,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_CH*ERR_W-1:0]  freq_err,
  output logic [NUM_CH*ERR_W-1:0]  ampl_err,
  output logic [NUM_CH-1:0]        no_cross,
  output logic [NUM_CH*CNT_W-1:0]  last_period
);

  logic                     r_busy;
  logic                     r_done;
  logic [WIN_W-1:0]         r_win;
  logic [WIN_W-1:0]         r_win_len;
  logic [CNT_W-1:0]         r_min_period;
  logic [CNT_W-1:0]         r_max_period;
  logic signed [DATA_W-1:0] r_min_ampl;
  logic signed [DATA_W-1:0] r_max_ampl;

  logic [NUM_CH-1:0] w_measuring;
  logic [WIN_W-1:0]  w_win_nxt;
  logic              w_go, w_all_meas, w_end;

  assign w_go       = start && !r_busy;
  assign w_all_meas = &w_measuring;
  assign w_win_nxt  = r_win + WIN_W'(1);
  // Terminal window sample is still processed by the channels this cycle
  assign w_end      = w_all_meas && ((r_win_len == '0) || (smpl_vld && (w_win_nxt == r_win_len)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_win        <= '0;
      r_win_len    <= '0;
      r_min_period <= '0;
      r_max_period <= '0;
      r_min_ampl   <= '0;
      r_max_ampl   <= '0;
    end else begin
      r_done <= w_end;
      if (w_go) begin
        r_busy       <= 1'b1;
        r_win        <= '0;
        r_win_len    <= win_len;
        r_min_period <= min_period;
        r_max_period <= max_period;
        r_min_ampl   <= min_ampl;
        r_max_ampl   <= max_ampl;
      end else begin
        if (r_done) r_busy <= 1'b0;
        if (w_all_meas && smpl_vld) r_win <= w_win_nxt;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    audio_mon_chan #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W),
      .ERR_W  (ERR_W),
      .WARMUP (WARMUP)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .smpl_vld    (smpl_vld),
      .sample      (aud_in[k*DATA_W +: DATA_W]),
      .go          (w_go),
      .stop        (w_end),
      .min_period  (r_min_period),
      .max_period  (r_max_period),
      .min_ampl    (r_min_ampl),
      .max_ampl    (r_max_ampl),
      .measuring   (w_measuring[k]),
      .freq_err    (freq_err[k*ERR_W +: ERR_W]),
      .ampl_err    (ampl_err[k*ERR_W +: ERR_W]),
      .no_cross    (no_cross[k]),
      .last_period (last_period[k*CNT_W +: CNT_W])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_audio_monitor.sv
// ============================================================================
// Module      : tb_audio_monitor
// Description : Directed self-checking bench for audio_monitor (default,
//               WARMUP=0 and ERR_W=4 instances share one stimulus).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_audio_monitor;

  localparam int c_k_sine   = 0;
  localparam int c_k_square = 1;
  localparam int c_k_const  = 2;

  logic        clk = 1'b0;
  logic        rst_n, smpl_vld, start;
  logic [31:0] aud_in;
  logic [23:0] win_len;
  logic [15:0] min_period, max_period, min_ampl, max_ampl;

  logic        busy, done, busy_w0, done_w0, busy_e4, done_e4;
  logic [31:0] freq_err, ampl_err, last_period;
  logic [31:0] freq_err_w0, ampl_err_w0, last_period_w0, last_period_e4;
  logic [7:0]  freq_err_e4, ampl_err_e4;
  logic [1:0]  no_cross, no_cross_w0, no_cross_e4;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_n    = 0;
  int done_at  = -1;
  int done_cnt = 0;
  int done_w0_cnt = 0;
  int done_e4_cnt = 0;

  always #5 clk = ~clk;

  audio_monitor u_dut (
    .clk(clk), .rst_n(rst_n), .smpl_vld(smpl_vld), .aud_in(aud_in), .start(start),
    .win_len(win_len), .min_period(min_period), .max_period(max_period),
    .min_ampl(min_ampl), .max_ampl(max_ampl), .busy(busy), .done(done),
    .freq_err(freq_err), .ampl_err(ampl_err), .no_cross(no_cross), .last_period(last_period)
  );

  audio_monitor #(.WARMUP(0)) u_dut_w0 (
    .clk(clk), .rst_n(rst_n), .smpl_vld(smpl_vld), .aud_in(aud_in), .start(start),
    .win_len(win_len), .min_period(min_period), .max_period(max_period),
    .min_ampl(min_ampl), .max_ampl(max_ampl), .busy(busy_w0), .done(done_w0),
    .freq_err(freq_err_w0), .ampl_err(ampl_err_w0), .no_cross(no_cross_w0),
    .last_period(last_period_w0)
  );

  audio_monitor #(.ERR_W(4)) u_dut_e4 (
    .clk(clk), .rst_n(rst_n), .smpl_vld(smpl_vld), .aud_in(aud_in), .start(start),
    .win_len(win_len), .min_period(min_period), .max_period(max_period),
    .min_ampl(min_ampl), .max_ampl(max_ampl), .busy(busy_e4), .done(done_e4),
    .freq_err(freq_err_e4), .ampl_err(ampl_err_e4), .no_cross(no_cross_e4),
    .last_period(last_period_e4)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] gen(input int kind, input int amp, input int n);
    int q[16];
    int v;
    q = '{0, 383, 707, 924, 1000, 924, 707, 383, 0, -383, -707, -924, -1000, -924, -707, -383};
    case (kind)
      c_k_sine:   v = amp * q[n % 16] / 1000;
      c_k_square: v = ((n % 40) < 20) ? amp : -amp;
      default:    v = 100;
    endcase
    return 16'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (done) begin
      done_cnt++;
      done_at = cur_n;
    end
    if (done_w0) done_w0_cnt++;
    if (done_e4) done_e4_cnt++;
  endtask

  // Valid sample cycle followed by a non-valid cycle carrying negative junk
  task automatic send(input logic [15:0] s0, input logic [15:0] s1);
    aud_in   = {s1, s0};
    smpl_vld = 1'b1;
    tick();
    aud_in   = 32'h8001_8001;
    smpl_vld = 1'b0;
    tick();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic run(input int k0, input int a0, input int k1, input int a1, input int wl,
                     input int nsamp, input int dup_at, input int rst_at);
    done_cnt    = 0;
    done_w0_cnt = 0;
    done_e4_cnt = 0;
    done_at     = -1;
    min_period  = 16'd12;
    max_period  = 16'd20;
    min_ampl    = 16'd2400;
    max_ampl    = 16'd4000;
    win_len     = 24'(wl);
    start       = 1'b1;
    tick();
    start       = 1'b0;
    check_eq("busy_after_start", busy, 1);
    // Limits must have been captured at start
    min_period  = 16'd100;
    max_period  = 16'd200;
    min_ampl    = 16'hFFFB;
    max_ampl    = 16'hFFFF;
    win_len     = 24'd3;
    for (int n = 0; n < nsamp; n++) begin
      if (n == dup_at) start = 1'b1;
      if (n == rst_at) begin
        check_eq("pre_reset_ampl_err1", ampl_err[31:16], 52);
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_freq_err", freq_err, 0);
        check_eq("abort_ampl_err", ampl_err, 0);
        check_eq("abort_no_cross", no_cross, 0);
        check_eq("abort_last_period", last_period, 0);
        tick();
        rst_n = 1'b1;
      end
      cur_n = n;
      send(gen(k0, a0, n), gen(k1, a1, n));
      start = 1'b0;
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; smpl_vld = 1'b0; start = 1'b0; aud_in = '0; win_len = '0;
    min_period = '0; max_period = '0; min_ampl = '0; max_ampl = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_freq_err", freq_err, 0);
    check_eq("rst_ampl_err", ampl_err, 0);
    check_eq("rst_no_cross", no_cross, 0);
    check_eq("rst_last_period", last_period, 0);
    rst_n = 1'b1;
    tick();

    // Clean sine on both channels
    run(c_k_sine, 3000, c_k_sine, 3000, 1600, 1800, -1, -1);
    check_eq("s1_done_cnt", done_cnt, 1);
    check_eq("s1_done_at", done_at, 1760);
    check_eq("s1_freq_err", freq_err, 0);
    check_eq("s1_ampl_err", ampl_err, 0);
    check_eq("s1_last_period0", last_period[15:0], 16);
    check_eq("s1_last_period1", last_period[31:16], 16);
    check_eq("s1_no_cross", no_cross, 0);
    check_eq("s1_busy_end", busy, 0);
    apply_reset();

    // Square period 40 on ch0 is out of range every crossing
    run(c_k_square, 3000, c_k_sine, 3000, 4000, 4440, -1, -1);
    check_eq("s2_done_at", done_at, 4400);
    check_eq("s2_freq_err0", freq_err[15:0], 100);
    check_eq("s2_freq_err1", freq_err[31:16], 0);
    check_eq("s2_ampl_err", ampl_err, 0);
    check_eq("s2_last_period0", last_period[15:0], 40);
    check_eq("s2_last_period1", last_period[31:16], 16);
    check_eq("s2_e4_freq_err0_sat", freq_err_e4[3:0], 15);
    check_eq("s2_e4_freq_err1", freq_err_e4[7:4], 0);
    check_eq("s2_e4_ampl_err", ampl_err_e4, 0);
    check_eq("s2_e4_last_period0", last_period_e4[15:0], 40);
    check_eq("s2_e4_no_cross", no_cross_e4, 0);
    check_eq("s2_e4_done_cnt", done_e4_cnt, 1);
    check_eq("s2_e4_busy_end", busy_e4, 0);
    apply_reset();

    // Over-amplitude ch1, with a start pulse while busy
    run(c_k_sine, 3000, c_k_sine, 5000, 1600, 1800, 800, -1);
    check_eq("s3_done_cnt", done_cnt, 1);
    check_eq("s3_done_at", done_at, 1760);
    check_eq("s3_ampl_err0", ampl_err[15:0], 0);
    check_eq("s3_ampl_err1", ampl_err[31:16], 100);
    check_eq("s3_freq_err", freq_err, 0);
    apply_reset();

    // ch0 never crosses: default stalls in warm-up, WARMUP=0 completes
    run(c_k_const, 0, c_k_sine, 3000, 200, 600, -1, -1);
    check_eq("s4_stall_busy", busy, 1);
    check_eq("s4_stall_done_cnt", done_cnt, 0);
    check_eq("s4_w0_done_cnt", done_w0_cnt, 1);
    check_eq("s4_w0_busy_end", busy_w0, 0);
    check_eq("s4_w0_no_cross", no_cross_w0, 2'b01);
    check_eq("s4_w0_freq_err", freq_err_w0, 0);
    check_eq("s4_w0_ampl_err", ampl_err_w0, 0);
    check_eq("s4_w0_last_period", last_period_w0, 32'h0010_0000);
    apply_reset();

    // Reset mid-run aborts with no done
    run(c_k_sine, 3000, c_k_sine, 5000, 1600, 1100, -1, 1000);
    check_eq("s5_done_cnt", done_cnt, 0);
    check_eq("s5_busy", busy, 0);

    // Normal run after abort
    run(c_k_sine, 3000, c_k_sine, 3000, 1600, 1800, -1, -1);
    check_eq("s6_done_cnt", done_cnt, 1);
    check_eq("s6_done_at", done_at, 1760);
    check_eq("s6_freq_err", freq_err, 0);
    check_eq("s6_ampl_err", ampl_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
